// File: rtl/apu_frame_sequencer_pkg.sv
// Shared APU frame-sequencer definitions: step counts, counter width,
// sequence-mode encoding and the $4017 configuration payload.
package apu_frame_sequencer_pkg;

    // Step-counter width and default step counts (APU ticks from frame start)
    localparam int unsigned DEF_CNT_W = 15;
    localparam int unsigned DEF_Q1    = 3729;
    localparam int unsigned DEF_Q2    = 7457;
    localparam int unsigned DEF_Q3    = 11186;
    localparam int unsigned DEF_Q4    = 14915;
    localparam int unsigned DEF_Q5    = 18641;

    // $4017 bit 7 encoding
    typedef enum logic {
        MODE_4STEP = 1'b0,
        MODE_5STEP = 1'b1
    } seq_mode_e;

    // Latched frame-register configuration
    typedef struct packed {
        seq_mode_e mode;
        logic      inhibit;
    } frame_cfg_t;

    localparam frame_cfg_t CFG_RESET = '{mode: MODE_4STEP, inhibit: 1'b0};

endpackage : apu_frame_sequencer_pkg

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer.
// Counts APU ticks and produces quarter-frame pulses (envelopes), half-frame
// pulses (length counters / sweeps) and the frame IRQ flag, in 4-step or
// 5-step mode as configured by $4017 writes.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   apu_tick        - one-clk enable per APU cycle
//   wr_en           - $4017 write strobe; wr_mode / wr_irq_inhibit qualify it
//   irq_ack         - status-read strobe, clears frame_irq
//   quarter_tick    - registered one-clk quarter-frame pulse
//   half_tick       - registered one-clk half-frame pulse (subset of quarter)
//   frame_irq       - registered frame interrupt flag
module apu_frame_sequencer
    import apu_frame_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned Q1    = DEF_Q1,
    parameter int unsigned Q2    = DEF_Q2,
    parameter int unsigned Q3    = DEF_Q3,
    parameter int unsigned Q4    = DEF_Q4,
    parameter int unsigned Q5    = DEF_Q5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic apu_tick,
    input  logic wr_en,
    input  logic wr_mode,
    input  logic wr_irq_inhibit,
    input  logic irq_ack,
    output logic quarter_tick,
    output logic half_tick,
    output logic frame_irq
);

    localparam logic [CNT_W-1:0] STEP1 = CNT_W'(Q1);
    localparam logic [CNT_W-1:0] STEP2 = CNT_W'(Q2);
    localparam logic [CNT_W-1:0] STEP3 = CNT_W'(Q3);
    localparam logic [CNT_W-1:0] STEP4 = CNT_W'(Q4);
    localparam logic [CNT_W-1:0] STEP5 = CNT_W'(Q5);

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
    frame_cfg_t       cfg_q, cfg_d;
    logic             pending_q, pending_d;
    logic             quarter_q, quarter_d;
    logic             half_q, half_d;
    logic             irq_q, irq_d;
    logic             irq_set;

    // Step decode, pending-reset handling, config latch and IRQ flag update
    always_comb begin
        cnt_nxt   = cnt_q + CNT_W'(1);
        cnt_d     = cnt_q;
        cfg_d     = cfg_q;
        pending_d = pending_q;
        quarter_d = 1'b0;
        half_d    = 1'b0;
        irq_d     = irq_q;
        irq_set   = 1'b0;

        if (apu_tick) begin
            if (pending_q) begin
                // Deferred frame restart after a $4017 write; 5-step mode
                // clocks the units immediately.
                cnt_d     = '0;
                pending_d = 1'b0;
                if (cfg_q.mode == MODE_5STEP) begin
                    quarter_d = 1'b1;
                    half_d    = 1'b1;
                end
            end else begin
                cnt_d = cnt_nxt;
                if ((cnt_nxt == STEP1) || (cnt_nxt == STEP3)) begin
                    quarter_d = 1'b1;
                end
                if (cnt_nxt == STEP2) begin
                    quarter_d = 1'b1;
                    half_d    = 1'b1;
                end
                // Step 4 ends the 4-step frame; in 5-step mode it is silent
                if ((cnt_nxt == STEP4) && (cfg_q.mode == MODE_4STEP)) begin
                    quarter_d = 1'b1;
                    half_d    = 1'b1;
                    cnt_d     = '0;
                    irq_set   = ~cfg_q.inhibit;
                end
                if ((cnt_nxt == STEP5) && (cfg_q.mode == MODE_5STEP)) begin
                    quarter_d = 1'b1;
                    half_d    = 1'b1;
                    cnt_d     = '0;
                end
            end
        end

        // A write takes effect on config now; the counter restart waits for
        // the next APU tick (pending).
        if (wr_en) begin
            cfg_d.mode    = seq_mode_e'(wr_mode);
            cfg_d.inhibit = wr_irq_inhibit;
            pending_d     = 1'b1;
        end

        // Priority: inhibit-write clear > set > acknowledge
        if (wr_en && wr_irq_inhibit) begin
            irq_d = 1'b0;
        end else if (irq_set) begin
            irq_d = 1'b1;
        end else if (irq_ack) begin
            irq_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            cfg_q     <= CFG_RESET;
            pending_q <= 1'b0;
            quarter_q <= 1'b0;
            half_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            cfg_q     <= cfg_d;
            pending_q <= pending_d;
            quarter_q <= quarter_d;
            half_q    <= half_d;
            irq_q     <= irq_d;
        end
    end

    assign quarter_tick = quarter_q;
    assign half_tick    = half_q;
    assign frame_irq    = irq_q;

endmodule : apu_frame_sequencer

// File: tb/tb_apu_frame_sequencer.sv
// Directed bench for apu_frame_sequencer with a frame-table reference model.
module tb_apu_frame_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic apu_tick = 1'b0;
    logic wr_en = 1'b0;
    logic wr_mode = 1'b0;
    logic wr_irq_inhibit = 1'b0;
    logic irq_ack = 1'b0;
    logic quarter_tick, half_tick, frame_irq;

    apu_frame_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .apu_tick       (apu_tick),
        .wr_en          (wr_en),
        .wr_mode        (wr_mode),
        .wr_irq_inhibit (wr_irq_inhibit),
        .irq_ack        (irq_ack),
        .quarter_tick   (quarter_tick),
        .half_tick      (half_tick),
        .frame_irq      (frame_irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int q_total = 0;
    int h_total = 0;

    // Frame table: step positions and which units each step clocks per mode
    int unsigned step_at [5] = '{3729, 7457, 11186, 14915, 18641};
    bit qev [2][5] = '{'{1'b1, 1'b1, 1'b1, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1}};
    bit hev [2][5] = '{'{1'b0, 1'b1, 1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1}};
    int unsigned period [2] = '{14915, 18641};

    int unsigned m_pos = 0;
    int m_mode = 0;
    bit m_inh = 1'b0;
    bit m_pend = 1'b0;
    bit m_irq = 1'b0;
    bit exp_q = 1'b0;
    bit exp_h = 1'b0;

    task automatic model_reset();
        m_pos = 0; m_mode = 0; m_inh = 1'b0; m_pend = 1'b0;
        m_irq = 1'b0; exp_q = 1'b0; exp_h = 1'b0;
    endtask

    task automatic model_update(input bit tk, input bit wr, input bit wm, input bit wi, input bit ack);
        bit q = 1'b0;
        bit h = 1'b0;
        bit set_irq = 1'b0;
        if (tk) begin
            if (m_pend) begin
                m_pos = 0;
                m_pend = 1'b0;
                if (m_mode == 1) begin q = 1'b1; h = 1'b1; end
            end else begin
                m_pos = m_pos + 1;
                for (int i = 0; i < 5; i++)
                    if (m_pos == step_at[i]) begin
                        q = qev[m_mode][i];
                        h = hev[m_mode][i];
                    end
                if (m_pos == period[m_mode]) begin
                    m_pos = 0;
                    set_irq = (m_mode == 0) && !m_inh;
                end
            end
        end
        if (wr) begin
            m_mode = wm ? 1 : 0;
            m_inh = wi;
            m_pend = 1'b1;
        end
        if (wr && wi) m_irq = 1'b0;
        else if (set_irq) m_irq = 1'b1;
        else if (ack) m_irq = 1'b0;
        exp_q = q;
        exp_h = h;
    endtask

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual{q,h,irq}=%b expected=%b", name, cycle, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, compare after the edge
    task automatic step(input bit tk, input bit wr, input bit wm, input bit wi, input bit ack);
        apu_tick = tk; wr_en = wr; wr_mode = wm; wr_irq_inhibit = wi; irq_ack = ack;
        model_update(tk, wr, wm, wi, ack);
        @(negedge clk);
        cycle++;
        q_total += int'(quarter_tick);
        h_total += int'(half_tick);
        check("model", {quarter_tick, half_tick, frame_irq}, {exp_q, exp_h, m_irq});
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    int q0, h0;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_outputs", {quarter_tick, half_tick, frame_irq}, 3'b000);
        #1 rst_n = 1'b1;

        // 4-step frame from reset
        q0 = q_total; h0 = h_total;
        run(3728);
        check("before_q1", {quarter_tick, half_tick, frame_irq}, 3'b000);
        run(1);
        check("q1_mode0", {quarter_tick, half_tick, frame_irq}, 3'b100);
        run(7457 - 3729);
        check("q2_mode0", {quarter_tick, half_tick, frame_irq}, 3'b110);
        run(14915 - 7457);
        check("q4_mode0_irq", {quarter_tick, half_tick, frame_irq}, 3'b111);
        check_int("mode0_quarters", q_total - q0, 4);
        check_int("mode0_halves", h_total - h0, 2);

        // Acknowledge, then ack coincident with the next IRQ set
        run(3000);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("irq_ack_clears", {quarter_tick, half_tick, frame_irq}, 3'b000);
        run(14915 - 3001 - 1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("set_beats_ack", {quarter_tick, half_tick, frame_irq}, 3'b111);

        // Inhibit write clears IRQ and suppresses the next one
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("inhibit_clears", {quarter_tick, half_tick, frame_irq}, 3'b000);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mode0_pending_silent", {quarter_tick, half_tick, frame_irq}, 3'b000);
        run(14915);
        check("inhibited_wrap", {quarter_tick, half_tick, frame_irq}, 3'b110);

        // Switch to 5-step
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mode1_immediate", {quarter_tick, half_tick, frame_irq}, 3'b110);
        q0 = q_total; h0 = h_total;
        run(14915);
        check("mode1_step4_silent", {quarter_tick, half_tick, frame_irq}, 3'b000);
        run(18641 - 14915);
        check("mode1_q5", {quarter_tick, half_tick, frame_irq}, 3'b110);
        check_int("mode1_quarters", q_total - q0, 4);
        check_int("mode1_halves", h_total - h0, 2);

        // Back to 4-step, then a 5-step write coincident with a tick at cnt=100
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run(100);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("wr_with_tick", {quarter_tick, half_tick, frame_irq}, 3'b000);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pending_reset_mode1", {quarter_tick, half_tick, frame_irq}, 3'b110);

        // Async reset mid-frame at cnt=5000, between clock edges
        run(5000);
        apu_tick = 1'b0;
        #1 rst_n = 1'b0;
        #1 check("async_reset", {quarter_tick, half_tick, frame_irq}, 3'b000);
        model_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;
        run(3729);
        check("post_reset_q1", {quarter_tick, half_tick, frame_irq}, 3'b100);
        run(14915 - 3729);
        check("post_reset_mode0", {quarter_tick, half_tick, frame_irq}, 3'b111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_apu_frame_sequencer
